// File: rtl/multicore_programmer_pkg.sv
// Shared definitions for the multicore core programmer: command codes,
// sequencer states and a sizing helper for the core-index register.
package programmer_pkg;

    localparam logic [3:0] CMD_ROM_CLR   = 4'h1;
    localparam logic [3:0] CMD_ROM_INC   = 4'h2;
    localparam logic [3:0] CMD_ROM_DEC   = 4'h3;
    localparam logic [3:0] CMD_ROM_LOAD  = 4'h4;
    localparam logic [3:0] CMD_CORE_CLR  = 4'h5;
    localparam logic [3:0] CMD_CORE_INC  = 4'h6;
    localparam logic [3:0] CMD_CORE_DEC  = 4'h7;
    localparam logic [3:0] CMD_BCAST_ON  = 4'h8;
    localparam logic [3:0] CMD_BCAST_OFF = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2
    } prog_state_t;

    // A single core still needs a one-bit index register.
    function automatic int core_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicore_programmer_if.sv
// Programming-port and core-side bus of the multicore programmer.
// master = external programming header side, slave = programmer.
interface multicore_programmer_if #(
    parameter int NumberOfCores = 2,
    parameter int RomAddrWidth  = 4,
    parameter int DataWidth     = 8
);
    logic                     PROG_MODE;
    logic [DataWidth-1:0]     PROG_DATA;
    logic                     PROG_PCK;
    logic                     PROG_SCK;
    logic [DataWidth-1:0]     PROG_OUT_DATA;
    logic [RomAddrWidth-1:0]  PROG_ROM_ADDR;
    logic                     CPU_RESET;
    logic                     CPU_WE;
    logic [NumberOfCores-1:0] CPU_WE_ADDR;
    logic                     PROG_ERR;

    modport master (
        output PROG_MODE, PROG_DATA, PROG_PCK, PROG_SCK,
        input  PROG_OUT_DATA, PROG_ROM_ADDR, CPU_RESET, CPU_WE, CPU_WE_ADDR, PROG_ERR
    );

    modport slave (
        input  PROG_MODE, PROG_DATA, PROG_PCK, PROG_SCK,
        output PROG_OUT_DATA, PROG_ROM_ADDR, CPU_RESET, CPU_WE, CPU_WE_ADDR, PROG_ERR
    );
endinterface

// File: rtl/multicore_programmer_strobe_sync.sv
// Two-flop synchroniser for an asynchronous strobe level followed by a
// rising-edge detector producing one single-cycle pulse per rising edge.
module prog_strobe_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/multicore_programmer.sv
// Core programmer: turns synchronised command/store strobes into ROM address
// sequencing and single-cycle write-enable pulses towards the PLC cores.
module multicore_programmer
    import programmer_pkg::*;
#(
    parameter int NumberOfCores = 2,
    parameter int RomAddrWidth  = 4,
    parameter int DataWidth     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    multicore_programmer_if.slave bus
);
    localparam int               CoreW    = core_idx_width(NumberOfCores);
    localparam logic [CoreW-1:0] LastCore = CoreW'(NumberOfCores - 1);

    logic                     w_pck;
    logic                     w_sck;
    logic                     w_ev;
    logic                     w_both;
    logic                     w_idle;
    logic                     w_go;
    logic                     w_go_cmd;
    logic [DataWidth-1:0]     w_go_data;
    logic                     w_drop;
    logic                     w_mode_rise;

    prog_state_t              r_state;
    logic                     r_pend_vld;
    logic                     r_pend_cmd;
    logic [DataWidth-1:0]     r_pend_data;
    logic [DataWidth-1:0]     r_cmd_data;
    logic [DataWidth-1:0]     r_out_data;
    logic [RomAddrWidth-1:0]  r_rom_addr;
    logic [CoreW-1:0]         r_core;
    logic                     r_bcast;
    logic                     r_we;
    logic [NumberOfCores-1:0] r_we_addr;
    logic                     r_cpu_reset;
    logic                     r_mode_q;
    logic                     r_err;

    prog_strobe_sync u_pck_sync (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (bus.PROG_PCK),
        .o_pulse (w_pck)
    );

    prog_strobe_sync u_sck_sync (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (bus.PROG_SCK),
        .o_pulse (w_sck)
    );

    function automatic logic code_is_valid(input logic [3:0] code);
        return (code >= CMD_ROM_CLR) && (code <= CMD_BCAST_OFF);
    endfunction

    function automatic logic [RomAddrWidth-1:0] rom_step(
        input logic [RomAddrWidth-1:0] addr,
        input logic [DataWidth-1:0]    data
    );
        case (data[3:0])
            CMD_ROM_CLR:  return '0;
            CMD_ROM_INC:  return addr + RomAddrWidth'(1);
            CMD_ROM_DEC:  return addr - RomAddrWidth'(1);
            CMD_ROM_LOAD: return RomAddrWidth'(data >> 4);
            default:      return addr;
        endcase
    endfunction

    // Core index wraps modulo NumberOfCores, which need not be a power of two.
    function automatic logic [CoreW-1:0] core_step(
        input logic [CoreW-1:0] idx,
        input logic [3:0]       code
    );
        case (code)
            CMD_CORE_CLR: return '0;
            CMD_CORE_INC: return (idx == LastCore) ? '0 : idx + CoreW'(1);
            CMD_CORE_DEC: return (idx == '0) ? LastCore : idx - CoreW'(1);
            default:      return idx;
        endcase
    endfunction

    function automatic logic [NumberOfCores-1:0] core_select(
        input logic [CoreW-1:0] idx,
        input logic             bcast
    );
        if (bcast) return '1;
        return NumberOfCores'(1) << idx;
    endfunction

    // Simultaneous PCK and SCK collapse into one command event.
    assign w_ev        = w_pck | w_sck;
    assign w_both      = w_pck & w_sck;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_go        = w_idle & (r_pend_vld | w_ev);
    assign w_go_cmd    = r_pend_vld ? r_pend_cmd  : w_pck;
    assign w_go_data   = r_pend_vld ? r_pend_data : bus.PROG_DATA;
    assign w_drop      = w_ev & ~w_idle & r_pend_vld;
    assign w_mode_rise = bus.PROG_MODE & ~r_mode_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_pend_vld  <= 1'b0;
            r_pend_cmd  <= 1'b0;
            r_pend_data <= '0;
            r_cmd_data  <= '0;
            r_out_data  <= '0;
            r_rom_addr  <= '0;
            r_core      <= '0;
            r_bcast     <= 1'b0;
            r_we        <= 1'b0;
            r_we_addr   <= '0;
            r_cpu_reset <= 1'b1;
            r_mode_q    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cpu_reset <= bus.PROG_MODE;
            r_mode_q    <= bus.PROG_MODE;
            r_we        <= 1'b0;
            r_we_addr   <= '0;

            if (!bus.PROG_MODE) begin
                r_state    <= ST_IDLE;
                r_pend_vld <= 1'b0;
            end else begin
                // In IDLE a waiting event is consumed, so a new one may take its place.
                if (w_idle) begin
                    r_pend_vld <= r_pend_vld & w_ev;
                end else if (w_ev && !r_pend_vld) begin
                    r_pend_vld <= 1'b1;
                end
                if (w_ev && !w_drop) begin
                    r_pend_cmd  <= w_pck;
                    r_pend_data <= bus.PROG_DATA;
                end

                case (r_state)
                    ST_IDLE: begin
                        if (w_go) begin
                            if (w_go_cmd) begin
                                r_cmd_data <= w_go_data;
                                r_state    <= ST_CMD;
                            end else begin
                                r_out_data <= w_go_data;
                                r_we       <= 1'b1;
                                r_we_addr  <= core_select(r_core, r_bcast);
                                r_state    <= ST_WRITE;
                            end
                        end
                    end
                    ST_CMD: begin
                        r_rom_addr <= rom_step(r_rom_addr, r_cmd_data);
                        r_core     <= core_step(r_core, r_cmd_data[3:0]);
                        if (r_cmd_data[3:0] == CMD_BCAST_ON) begin
                            r_bcast <= 1'b1;
                        end else if (r_cmd_data[3:0] == CMD_BCAST_OFF) begin
                            r_bcast <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end
                    ST_WRITE: begin
                        r_rom_addr <= r_rom_addr + RomAddrWidth'(1);
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            if (bus.PROG_MODE &&
                (w_both || w_drop || (r_state == ST_CMD && !code_is_valid(r_cmd_data[3:0])))) begin
                r_err <= 1'b1;
            end else if (w_mode_rise) begin
                r_err <= 1'b0;
            end
        end
    end

    // Write enable is gated so no core is written in a cycle with PROG_MODE low.
    assign bus.CPU_WE        = r_we & bus.PROG_MODE;
    assign bus.CPU_WE_ADDR   = r_we_addr & {NumberOfCores{bus.PROG_MODE}};
    assign bus.PROG_OUT_DATA = r_out_data;
    assign bus.PROG_ROM_ADDR = r_rom_addr;
    assign bus.CPU_RESET     = r_cpu_reset;
    assign bus.PROG_ERR      = r_err;

endmodule

// File: tb/tb_multicore_programmer.sv
// Bench for multicore_programmer with three cores, 4-bit ROM address, 8-bit data.
module tb_multicore_programmer;
    localparam int NC = 3;
    localparam int RA = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicore_programmer_if #(.NumberOfCores(NC), .RomAddrWidth(RA), .DataWidth(DW)) bus ();

    multicore_programmer #(.NumberOfCores(NC), .RomAddrWidth(RA), .DataWidth(DW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Write-pulse monitor sampled mid-cycle.
    int            we_cnt = 0;
    logic [NC-1:0] last_addr;
    logic [DW-1:0] last_data;
    logic [RA-1:0] last_rom;
    always @(negedge clk) begin
        if (bus.CPU_WE === 1'b1) begin
            we_cnt    = we_cnt + 1;
            last_addr = bus.CPU_WE_ADDR;
            last_data = bus.PROG_OUT_DATA;
            last_rom  = bus.PROG_ROM_ADDR;
        end
    end

    // Architectural reference model.
    int m_rom;
    int m_core;
    bit m_bcast;
    bit m_err;

    function automatic void m_reset();
        m_rom = 0; m_core = 0; m_bcast = 0; m_err = 0;
    endfunction

    function automatic void m_cmd(input logic [7:0] d);
        case (int'(d[3:0]))
            1: m_rom = 0;
            2: m_rom = (m_rom + 1) % 16;
            3: m_rom = (m_rom + 15) % 16;
            4: m_rom = int'(d[7:4]);
            5: m_core = 0;
            6: m_core = (m_core + 1) % NC;
            7: m_core = (m_core + NC - 1) % NC;
            8: m_bcast = 1;
            9: m_bcast = 0;
            default: m_err = 1;
        endcase
    endfunction

    function automatic logic [NC-1:0] m_sel();
        logic [NC-1:0] s;
        s = '0;
        if (m_bcast) s = '1;
        else s[m_core] = 1'b1;
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit pck, input bit sck, input logic [7:0] d);
        bus.PROG_DATA = d;
        bus.PROG_PCK  = pck;
        bus.PROG_SCK  = sck;
        tick(4);
        bus.PROG_PCK  = 1'b0;
        bus.PROG_SCK  = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.PROG_MODE = 1'b1;
        bus.PROG_PCK  = 1'b0;
        bus.PROG_SCK  = 1'b0;
        bus.PROG_DATA = '0;
        tick(2);
        rst = 1'b0;
        tick(2);
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PROG_MODE = 1'b0;
        bus.PROG_PCK  = 1'b0;
        bus.PROG_SCK  = 1'b0;
        bus.PROG_DATA = 8'hFF;
        tick(3);
        total++;
        if (bus.CPU_RESET !== 1'b1) begin
            bad++; $display("FAIL reset_cpu_reset got=%b exp=1", bus.CPU_RESET);
        end
        total++;
        if ({bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_OUT_DATA, bus.PROG_ROM_ADDR, bus.PROG_ERR} !== '0) begin
            bad++; $display("FAIL reset_outputs got we=%b sel=%b data=%h rom=%h err=%b exp all zero",
                            bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_OUT_DATA, bus.PROG_ROM_ADDR, bus.PROG_ERR);
        end
        rst = 1'b0;
        tick(1);
        total++;
        if (bus.CPU_RESET !== 1'b0) begin
            bad++; $display("FAIL cpu_reset_follows_mode_low got=%b exp=0", bus.CPU_RESET);
        end
        bus.PROG_MODE = 1'b1;
        tick(1);
        total++;
        if (bus.CPU_RESET !== 1'b1) begin
            bad++; $display("FAIL cpu_reset_follows_mode_high got=%b exp=1", bus.CPU_RESET);
        end
        tick(1);
        m_reset();
    endtask

    task automatic test_first_write();
        int n0;
        n0 = we_cnt;
        bus.PROG_DATA = 8'hA5;
        bus.PROG_SCK  = 1'b1;
        tick(2);
        total++;
        if (bus.CPU_WE !== 1'b0) begin
            bad++; $display("FAIL first_we_early got=%b exp=0", bus.CPU_WE);
        end
        tick(1);
        total++;
        if ({bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_OUT_DATA, bus.PROG_ROM_ADDR} !== {1'b1, 3'b001, 8'hA5, 4'h0}) begin
            bad++; $display("FAIL first_we got we=%b sel=%b data=%h rom=%h exp we=1 sel=001 data=a5 rom=0",
                            bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_OUT_DATA, bus.PROG_ROM_ADDR);
        end
        tick(1);
        total++;
        if ({bus.CPU_WE, bus.PROG_ROM_ADDR} !== {1'b0, 4'h1}) begin
            bad++; $display("FAIL first_we_end got we=%b rom=%h exp we=0 rom=1", bus.CPU_WE, bus.PROG_ROM_ADDR);
        end
        bus.PROG_SCK = 1'b0;
        tick(3);
        total++;
        if (we_cnt - n0 !== 1) begin
            bad++; $display("FAIL first_we_count got=%0d exp=1", we_cnt - n0);
        end
        m_rom = 1;
    endtask

    typedef struct {
        bit            is_cmd;
        logic [7:0]    d;
        logic [NC-1:0] sel;
        logic [RA-1:0] rom;
    } op_t;

    // Continues from the state left by test_first_write: rom=1, core 0, broadcast off.
    op_t dir_ops [0:20] = '{
        '{1, 8'h06, 3'b000, 4'h1}, '{0, 8'h11, 3'b010, 4'h2},
        '{1, 8'h06, 3'b000, 4'h2}, '{0, 8'h22, 3'b100, 4'h3},
        '{1, 8'h06, 3'b000, 4'h3}, '{0, 8'h33, 3'b001, 4'h4},
        '{1, 8'h07, 3'b000, 4'h4}, '{0, 8'h44, 3'b100, 4'h5},
        '{1, 8'hF4, 3'b000, 4'hF}, '{0, 8'h55, 3'b100, 4'h0},
        '{1, 8'h08, 3'b000, 4'h0}, '{0, 8'h66, 3'b111, 4'h1},
        '{1, 8'h09, 3'b000, 4'h1}, '{0, 8'h77, 3'b100, 4'h2},
        '{1, 8'h01, 3'b000, 4'h0}, '{1, 8'h03, 3'b000, 4'hF},
        '{1, 8'h02, 3'b000, 4'h0}, '{1, 8'h05, 3'b000, 4'h0},
        '{0, 8'h88, 3'b001, 4'h1}, '{1, 8'h47, 3'b000, 4'h1},
        '{0, 8'h99, 3'b100, 4'h2}
    };

    task automatic test_directed_ops();
        int n0;
        logic [RA-1:0] rom_we;
        for (int i = 0; i < 21; i++) begin
            n0 = we_cnt;
            strobe(dir_ops[i].is_cmd, !dir_ops[i].is_cmd, dir_ops[i].d);
            total++;
            if (we_cnt - n0 !== (dir_ops[i].is_cmd ? 0 : 1)) begin
                bad++; $display("FAIL dir_we_count op=%0d got=%0d exp=%0d", i, we_cnt - n0, dir_ops[i].is_cmd ? 0 : 1);
            end
            if (!dir_ops[i].is_cmd) begin
                rom_we = dir_ops[i].rom - 4'd1;
                total++;
                if ({last_addr, last_data, last_rom} !== {dir_ops[i].sel, dir_ops[i].d, rom_we}) begin
                    bad++; $display("FAIL dir_write op=%0d got sel=%b data=%h rom=%h exp sel=%b data=%h rom=%h",
                                    i, last_addr, last_data, last_rom, dir_ops[i].sel, dir_ops[i].d, rom_we);
                end
            end
            total++;
            if ({bus.PROG_ROM_ADDR, bus.PROG_ERR} !== {dir_ops[i].rom, 1'b0}) begin
                bad++; $display("FAIL dir_state op=%0d got rom=%h err=%b exp rom=%h err=0",
                                i, bus.PROG_ROM_ADDR, bus.PROG_ERR, dir_ops[i].rom);
            end
        end
    endtask

    task automatic test_error_flag();
        int n0;
        do_reset();
        n0 = we_cnt;
        strobe(1'b1, 1'b1, 8'h02);
        total++;
        if ({bus.PROG_ROM_ADDR, bus.PROG_ERR} !== {4'h1, 1'b1} || we_cnt != n0) begin
            bad++; $display("FAIL err_collision got rom=%h err=%b we=%0d exp rom=1 err=1 we=0",
                            bus.PROG_ROM_ADDR, bus.PROG_ERR, we_cnt - n0);
        end
        bus.PROG_MODE = 1'b0; tick(2);
        bus.PROG_MODE = 1'b1; tick(2);
        total++;
        if (bus.PROG_ERR !== 1'b0) begin
            bad++; $display("FAIL err_clear_mode got=%b exp=0", bus.PROG_ERR);
        end
        strobe(1'b1, 1'b0, 8'h0C);
        total++;
        if ({bus.PROG_ROM_ADDR, bus.PROG_ERR} !== {4'h1, 1'b1}) begin
            bad++; $display("FAIL err_bad_code got rom=%h err=%b exp rom=1 err=1", bus.PROG_ROM_ADDR, bus.PROG_ERR);
        end
        bus.PROG_MODE = 1'b0; tick(2);
        bus.PROG_MODE = 1'b1; tick(2);
        total++;
        if (bus.PROG_ERR !== 1'b0) begin
            bad++; $display("FAIL err_clear_mode2 got=%b exp=0", bus.PROG_ERR);
        end
    endtask

    task automatic test_mode_drop();
        int n0;
        do_reset();
        n0 = we_cnt;
        bus.PROG_DATA = 8'h3C;
        bus.PROG_SCK  = 1'b1;
        tick(3);
        bus.PROG_MODE = 1'b0;
        #1;
        total++;
        if ({bus.CPU_WE, bus.CPU_WE_ADDR, bus.CPU_RESET} !== {1'b0, 3'b000, 1'b1}) begin
            bad++; $display("FAIL mode_drop_we got we=%b sel=%b cpu_reset=%b exp we=0 sel=000 cpu_reset=1",
                            bus.CPU_WE, bus.CPU_WE_ADDR, bus.CPU_RESET);
        end
        tick(1);
        total++;
        if ({bus.CPU_RESET, bus.PROG_ROM_ADDR} !== {1'b0, 4'h0}) begin
            bad++; $display("FAIL mode_drop_state got cpu_reset=%b rom=%h exp cpu_reset=0 rom=0",
                            bus.CPU_RESET, bus.PROG_ROM_ADDR);
        end
        bus.PROG_SCK = 1'b0;
        tick(3);
        bus.PROG_MODE = 1'b1;
        tick(2);
        total++;
        if (we_cnt != n0 || bus.PROG_ROM_ADDR !== 4'h0) begin
            bad++; $display("FAIL mode_drop_after got we=%0d rom=%h exp we=0 rom=0", we_cnt - n0, bus.PROG_ROM_ADDR);
        end
        strobe(1'b0, 1'b1, 8'h11);
        total++;
        if ({last_addr, last_data, bus.PROG_ROM_ADDR} !== {3'b001, 8'h11, 4'h1} || we_cnt != n0 + 1) begin
            bad++; $display("FAIL mode_drop_resume got sel=%b data=%h rom=%h we=%0d exp sel=001 data=11 rom=1 we=1",
                            last_addr, last_data, bus.PROG_ROM_ADDR, we_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        bit         pck_s [0:5] = '{1, 0, 1, 0, 0, 0};
        bit         sck_s [0:5] = '{0, 1, 0, 1, 0, 0};
        logic [7:0] dat_s [0:5] = '{8'h00, 8'h00, 8'h06, 8'h5A, 8'h02, 8'h77};
        do_reset();
        n0 = we_cnt;
        for (int k = 0; k < 6; k++) begin
            bus.PROG_PCK  = pck_s[k];
            bus.PROG_SCK  = sck_s[k];
            bus.PROG_DATA = dat_s[k];
            tick(1);
        end
        tick(6);
        total++;
        if (we_cnt - n0 !== 1) begin
            bad++; $display("FAIL b2b_we_count got=%0d exp=1", we_cnt - n0);
        end
        total++;
        if ({last_addr, last_data, last_rom} !== {3'b010, 8'h5A, 4'h0}) begin
            bad++; $display("FAIL b2b_write got sel=%b data=%h rom=%h exp sel=010 data=5a rom=0",
                            last_addr, last_data, last_rom);
        end
        total++;
        if ({bus.PROG_ROM_ADDR, bus.PROG_ERR, bus.PROG_OUT_DATA} !== {4'h2, 1'b1, 8'h5A}) begin
            bad++; $display("FAIL b2b_state got rom=%h err=%b data=%h exp rom=2 err=1 data=5a",
                            bus.PROG_ROM_ADDR, bus.PROG_ERR, bus.PROG_OUT_DATA);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        strobe(1'b1, 1'b0, 8'h54);
        bus.PROG_DATA = 8'h99;
        bus.PROG_SCK  = 1'b1;
        tick(3);
        total++;
        if ({bus.CPU_WE, bus.PROG_ROM_ADDR} !== {1'b1, 4'h5}) begin
            bad++; $display("FAIL mid_write_we got we=%b rom=%h exp we=1 rom=5", bus.CPU_WE, bus.PROG_ROM_ADDR);
        end
        rst = 1'b1;
        tick(1);
        total++;
        if ({bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_ROM_ADDR, bus.CPU_RESET} !== {1'b0, 3'b000, 4'h0, 1'b1}) begin
            bad++; $display("FAIL mid_write_reset got we=%b sel=%b rom=%h cpu_reset=%b exp we=0 sel=000 rom=0 cpu_reset=1",
                            bus.CPU_WE, bus.CPU_WE_ADDR, bus.PROG_ROM_ADDR, bus.CPU_RESET);
        end
        rst = 1'b0;
        bus.PROG_SCK = 1'b0;
        tick(3);
    endtask

    task automatic test_random();
        int n0;
        int kind;
        logic [7:0] d;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            d    = 8'($urandom);
            n0   = we_cnt;
            if (kind <= 3) begin
                strobe(1'b0, 1'b1, d);
                total++;
                if (we_cnt - n0 !== 1 || {last_addr, last_data, last_rom} !== {m_sel(), d, 4'(m_rom)}) begin
                    bad++; $display("FAIL rnd_write it=%0d got we=%0d sel=%b data=%h rom=%h exp we=1 sel=%b data=%h rom=%h",
                                    it, we_cnt - n0, last_addr, last_data, last_rom, m_sel(), d, 4'(m_rom));
                end
                m_rom = (m_rom + 1) % 16;
            end else if (kind <= 8) begin
                d[3:0] = 4'($urandom_range(0, 11));
                if (kind == 8) begin
                    strobe(1'b1, 1'b1, d);
                    m_err = 1;
                end else begin
                    strobe(1'b1, 1'b0, d);
                end
                m_cmd(d);
                total++;
                if (we_cnt != n0) begin
                    bad++; $display("FAIL rnd_cmd_no_we it=%0d got=%0d exp=0", it, we_cnt - n0);
                end
            end else begin
                bus.PROG_MODE = 1'b0;
                tick(1);
                strobe(1'b0, 1'b1, d);
                bus.PROG_MODE = 1'b1;
                tick(2);
                m_err = 0;
                total++;
                if (we_cnt != n0) begin
                    bad++; $display("FAIL rnd_off_no_we it=%0d got=%0d exp=0", it, we_cnt - n0);
                end
            end
            total++;
            if ({bus.PROG_ROM_ADDR, bus.PROG_ERR} !== {4'(m_rom), m_err}) begin
                bad++; $display("FAIL rnd_state it=%0d kind=%0d got rom=%h err=%b exp rom=%h err=%b",
                                it, kind, bus.PROG_ROM_ADDR, bus.PROG_ERR, 4'(m_rom), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_directed_ops();
        test_error_flag();
        test_mode_drop();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
